// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Brief    : Round-robin arbiter sharing one single-port RAM between the
//            instruction-fetch and load/store paths, with an access timeout.
// Revision : 1.0  initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            if_req,
    input  logic [AW-1:0]   if_addr,
    output logic            if_ack,
    output logic [DW-1:0]   if_rdata,
    output logic            if_err,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [AW-1:0]   d_addr,
    input  logic [DW-1:0]   d_wdata,
    input  logic [DW/8-1:0] d_wstrb,
    output logic            d_ack,
    output logic [DW-1:0]   d_rdata,
    output logic            d_err,
    output logic            mem_req,
    output logic            mem_we,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    output logic [DW/8-1:0] mem_wstrb,
    input  logic            mem_ack,
    input  logic [DW-1:0]   mem_rdata,
    output logic            busy
);

    localparam int SW = DW / 8;
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    // Last BUSY cycle allowed before the access is declared hung.
    localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
    localparam logic OWN_FETCH = 1'b0;
    localparam logic OWN_DATA  = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state, state_nx;
    logic            owner, owner_nx;
    logic            last_owner, last_owner_nx;
    logic [CW-1:0]   cnt, cnt_nx;
    logic            mem_req_nx, mem_we_nx;
    logic [AW-1:0]   mem_addr_nx;
    logic [DW-1:0]   mem_wdata_nx;
    logic [SW-1:0]   mem_wstrb_nx;
    logic            if_ack_nx, if_err_nx, d_ack_nx, d_err_nx;
    logic [DW-1:0]   if_rdata_nx, d_rdata_nx;
    logic            busy_nx;
    logic            grant_data;
    logic            timed_out;

    always_comb begin
        state_nx      = state;
        owner_nx      = owner;
        last_owner_nx = last_owner;
        cnt_nx        = cnt;
        mem_req_nx    = mem_req;
        mem_we_nx     = mem_we;
        mem_addr_nx   = mem_addr;
        mem_wdata_nx  = mem_wdata;
        mem_wstrb_nx  = mem_wstrb;
        if_ack_nx     = 1'b0;
        if_rdata_nx   = if_rdata;
        if_err_nx     = if_err;
        d_ack_nx      = 1'b0;
        d_rdata_nx    = d_rdata;
        d_err_nx      = d_err;
        grant_data    = 1'b0;
        timed_out     = 1'b0;

        case (state)
            IDLE: begin
                if (if_req || d_req) begin
                    // On contention the side that did not go last wins.
                    grant_data = d_req && (!if_req || (last_owner == OWN_FETCH));
                    owner_nx   = grant_data ? OWN_DATA : OWN_FETCH;
                    cnt_nx     = '0;
                    mem_req_nx = 1'b1;
                    state_nx   = BUSY;
                    if (grant_data) begin
                        mem_we_nx    = d_we;
                        mem_addr_nx  = d_addr;
                        mem_wdata_nx = d_wdata;
                        mem_wstrb_nx = d_wstrb;
                    end else begin
                        mem_we_nx    = 1'b0;
                        mem_addr_nx  = if_addr;
                        mem_wdata_nx = '0;
                        mem_wstrb_nx = '0;
                    end
                end
            end

            BUSY: begin
                // An ack arriving in the final allowed cycle still counts as success.
                timed_out = (TIMEOUT != 0) && !mem_ack && (cnt == CNT_LAST);
                if (mem_ack || timed_out) begin
                    mem_req_nx = 1'b0;
                    state_nx   = RESP;
                    if (owner == OWN_DATA) begin
                        d_ack_nx   = 1'b1;
                        d_err_nx   = !mem_ack;
                        d_rdata_nx = (mem_ack && !mem_we) ? mem_rdata : '0;
                    end else begin
                        if_ack_nx   = 1'b1;
                        if_err_nx   = !mem_ack;
                        if_rdata_nx = mem_ack ? mem_rdata : '0;
                    end
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end

            RESP: begin
                last_owner_nx = owner;
                state_nx      = IDLE;
            end

            default: state_nx = IDLE;
        endcase

        busy_nx = (state_nx != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            owner      <= OWN_FETCH;
            last_owner <= OWN_DATA;
            cnt        <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_wstrb  <= '0;
            if_ack     <= 1'b0;
            if_rdata   <= '0;
            if_err     <= 1'b0;
            d_ack      <= 1'b0;
            d_rdata    <= '0;
            d_err      <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nx;
            owner      <= owner_nx;
            last_owner <= last_owner_nx;
            cnt        <= cnt_nx;
            mem_req    <= mem_req_nx;
            mem_we     <= mem_we_nx;
            mem_addr   <= mem_addr_nx;
            mem_wdata  <= mem_wdata_nx;
            mem_wstrb  <= mem_wstrb_nx;
            if_ack     <= if_ack_nx;
            if_rdata   <= if_rdata_nx;
            if_err     <= if_err_nx;
            d_ack      <= d_ack_nx;
            d_rdata    <= d_rdata_nx;
            d_err      <= d_err_nx;
            busy       <= busy_nx;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Brief    : Scoreboard bench for mem_port_arbiter with a behavioural RAM.
// Revision : 1.0  initial release
// ============================================================================
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        if_err;
    logic        d_req, d_we;
    logic [31:0] d_addr, d_wdata;
    logic [3:0]  d_wstrb;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        d_err;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        busy;

    mem_port_arbiter #(.AW(32), .DW(32), .TIMEOUT(4)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata), .if_err(if_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
        .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .busy(busy)
    );

    initial forever #5 clk = ~clk;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } djob_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic [31:0] if_jobs[$];
    djob_t       d_jobs[$];
    exp_t        exp_if[$];
    exp_t        exp_d[$];
    bit          ack_log[$];

    int n_checks = 0;
    int n_errors = 0;
    int mem_wait = 0;
    bit rand_wait = 1'b0;
    bit mem_hang  = 1'b0;
    bit stray_ack = 1'b0;

    // Contents of the behavioural RAM as a pure function of the address.
    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        if (a == 32'h10) return 32'h00500093;
        return {a[15:0] ^ 16'h1234, ~a[15:0]};
    endfunction

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push_d(input logic we, input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] ws);
        djob_t j;
        j.we = we; j.addr = a; j.wdata = wd; j.wstrb = ws;
        d_jobs.push_back(j);
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int k = 0; k < 300 && !ok; k++) begin
            @(negedge clk);
            ok = (if_jobs.size() == 0) && (d_jobs.size() == 0) && (exp_if.size() == 0) &&
                 (exp_d.size() == 0) && !if_req && !d_req && !busy;
        end
        check("idle_wait", {95'b0, ok}, 96'd1);
    endtask

    // RAM responder: acks after mem_wait (or random 0..3) extra BUSY cycles.
    initial begin : mem_model
        int bcnt = 0;
        int cur_wait = 0;
        mem_ack = 1'b0;
        mem_rdata = 32'h0;
        forever begin
            @(posedge clk); #1;
            bcnt = mem_req ? bcnt + 1 : 0;
            if (bcnt == 1) cur_wait = rand_wait ? int'($urandom_range(0, 3)) : mem_wait;
            if (mem_req && !mem_hang && (bcnt == cur_wait + 1)) begin
                mem_ack   = 1'b1;
                mem_rdata = mem_fn(mem_addr);
            end else begin
                mem_ack   = stray_ack;
                mem_rdata = $urandom;
            end
        end
    end

    initial begin : fetch_agent
        logic [31:0] a;
        exp_t        e;
        bit          done;
        if_req = 1'b0;
        if_addr = 32'h0;
        forever begin
            @(negedge clk);
            while (if_jobs.size() > 0 && !reset) begin
                a = if_jobs.pop_front();
                if_req  = 1'b1;
                if_addr = a;
                e.rdata = mem_hang ? 32'h0 : mem_fn(a);
                e.err   = mem_hang;
                exp_if.push_back(e);
                done = 1'b0;
                for (int k = 0; k < 64 && !done && !reset; k++) begin
                    @(posedge clk); #1;
                    done = if_ack;
                end
                if (!reset) check("if_ack_wait", {95'b0, done}, 96'd1);
                if (!done) begin
                    exp_if.delete();
                    if_jobs.delete();
                end
            end
            if_req = 1'b0;
        end
    end

    initial begin : data_agent
        djob_t j;
        exp_t  e;
        bit    done;
        d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0; d_wstrb = 4'h0;
        forever begin
            @(negedge clk);
            while (d_jobs.size() > 0 && !reset) begin
                j = d_jobs.pop_front();
                d_req = 1'b1; d_we = j.we; d_addr = j.addr; d_wdata = j.wdata; d_wstrb = j.wstrb;
                e.rdata = (j.we || mem_hang) ? 32'h0 : mem_fn(j.addr);
                e.err   = mem_hang;
                exp_d.push_back(e);
                done = 1'b0;
                for (int k = 0; k < 64 && !done && !reset; k++) begin
                    @(posedge clk); #1;
                    done = d_ack;
                end
                if (!reset) check("d_ack_wait", {95'b0, done}, 96'd1);
                if (!done) begin
                    exp_d.delete();
                    d_jobs.delete();
                end
            end
            d_req = 1'b0;
        end
    end

    initial begin : monitor
        bit   prev_if = 1'b0;
        bit   prev_d  = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (if_ack) begin
                check("if_ack_pulse", {95'b0, prev_if}, 96'd0);
                check("if_ack_expected", {95'b0, exp_if.size() > 0}, 96'd1);
                if (exp_if.size() > 0) begin
                    e = exp_if.pop_front();
                    check("if_rdata", if_rdata, e.rdata);
                    check("if_err", if_err, e.err);
                end
                ack_log.push_back(1'b0);
            end
            if (d_ack) begin
                check("d_ack_pulse", {95'b0, prev_d}, 96'd0);
                check("d_ack_expected", {95'b0, exp_d.size() > 0}, 96'd1);
                if (exp_d.size() > 0) begin
                    e = exp_d.pop_front();
                    check("d_rdata", d_rdata, e.rdata);
                    check("d_err", d_err, e.err);
                end
                ack_log.push_back(1'b1);
            end
            prev_if = if_ack;
            prev_d  = d_ack;
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int gap;
        int ngaps;
        reset = 1'b1;
        #1;
        check("reset_outputs", {mem_req, busy, if_ack, d_ack, if_err, d_err, mem_we}, 96'd0);
        check("reset_data", {mem_addr, if_rdata, d_rdata}, 96'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Fetch-only read with zero-wait memory
        mem_wait = 0;
        @(posedge clk); #3;
        if_jobs.push_back(32'h10);
        @(negedge clk); #2;
        check("t1_cycle0", {if_req, mem_req, busy}, 96'b100);
        @(posedge clk); #1;
        check("t1_cycle1_mem", {mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata},
              {1'b1, 1'b0, 32'h10, 4'h0, 32'h0});
        check("t1_cycle1_noack", {if_ack, d_ack}, 96'd0);
        @(posedge clk); #1;
        check("t1_cycle2_ack", {if_ack, d_ack, mem_req, busy}, 96'b1001);
        check("t1_rdata", {if_rdata, if_err}, {32'h00500093, 1'b0});
        wait_idle();

        // Contention straight after reset
        @(posedge clk); #3;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        ack_log.delete();
        @(posedge clk); #3;
        if_jobs.push_back(32'h20);
        if_jobs.push_back(32'h24);
        push_d(1'b0, 32'h30, 32'h0, 4'h0);
        push_d(1'b1, 32'h34, 32'h11223344, 4'hF);
        gap = -1;
        ngaps = 0;
        for (int k = 0; k < 80 && ack_log.size() < 4; k++) begin
            @(negedge clk);
            if (busy) begin
                if (gap > 0) begin
                    check("t2_idle_gap", gap, 96'd1);
                    ngaps++;
                end
                gap = 0;
            end else if (gap >= 0) begin
                gap++;
            end
        end
        wait_idle();
        check("t2_gap_count", ngaps, 96'd3);
        check("t2_grant_count", ack_log.size(), 96'd4);
        if (ack_log.size() == 4)
            check("t2_grant_order", {ack_log[0], ack_log[1], ack_log[2], ack_log[3]}, 96'b0101);

        // Store with three wait cycles; ack lands in the last allowed cycle
        mem_wait = 3;
        @(posedge clk); #3;
        push_d(1'b1, 32'h100, 32'hDEADBEEF, 4'b0011);
        @(negedge clk); #2;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            check("t3_store_hold", {mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, d_ack},
                  {1'b1, 1'b1, 32'h100, 32'hDEADBEEF, 4'b0011, 1'b0});
        end
        @(posedge clk); #1;
        check("t3_store_ack", {d_ack, d_err, d_rdata, mem_req}, {1'b1, 1'b0, 32'h0, 1'b0});
        wait_idle();

        // Hung load times out after four BUSY cycles
        mem_wait = 0;
        mem_hang = 1'b1;
        @(posedge clk); #3;
        push_d(1'b0, 32'h200, 32'h0, 4'h0);
        @(negedge clk); #2;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            check("t4_mem_req_held", {mem_req, d_ack}, 96'b10);
        end
        @(posedge clk); #1;
        check("t4_timeout_ack", {d_ack, d_err, d_rdata, mem_req}, {1'b1, 1'b1, 32'h0, 1'b0});
        wait_idle();
        mem_hang = 1'b0;
        @(posedge clk); #3;
        if_jobs.push_back(32'h300);
        wait_idle();

        // Reset in the middle of an access
        mem_wait = 10;
        @(posedge clk); #3;
        push_d(1'b0, 32'h400, 32'h0, 4'h0);
        @(negedge clk); #2;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("t5_busy_before", {mem_req, busy}, 96'b11);
        #2;
        reset = 1'b1;
        #1;
        check("t5_async_clear", {mem_req, busy, if_ack, d_ack}, 96'd0);
        repeat (2) begin
            @(posedge clk); #1;
            check("t5_quiet_in_reset", {if_ack, d_ack, mem_req, busy}, 96'd0);
        end
        @(negedge clk);
        reset = 1'b0;
        mem_wait = 0;
        ack_log.delete();
        @(posedge clk); #3;
        if_jobs.push_back(32'h500);
        push_d(1'b0, 32'h504, 32'h0, 4'h0);
        wait_idle();
        check("t5_grant_count", ack_log.size(), 96'd2);
        check("t5_first_grant", {95'b0, (ack_log.size() > 0) ? ack_log[0] : 1'b1}, 96'd0);

        // Stray mem_ack while idle
        @(posedge clk); #3;
        stray_ack = 1'b1;
        @(posedge clk); #3;
        stray_ack = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check("t6_stray_ignored", {if_ack, d_ack, busy, mem_req}, 96'd0);
        end

        // Mixed traffic with random memory latency
        rand_wait = 1'b1;
        @(posedge clk); #3;
        for (int k = 0; k < 8; k++) begin
            if_jobs.push_back($urandom & 32'h0000_FFFC);
            push_d(1'($urandom_range(0, 1)), $urandom & 32'h0000_FFFC, $urandom,
                   4'($urandom_range(1, 15)));
        end
        wait_idle();
        rand_wait = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
